// File: rtl/memport_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store path.
// One transaction outstanding at a time; data has priority, bounded by a starvation limit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction outstanding; arbitrate and drive mem_req
// WAIT_IF | fetch granted by memory, waiting for its mem_rvalid
// WAIT_D  | data access granted by memory, waiting for its mem_rvalid
module memport_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,

    output logic [DW-1:0]   rdata,
    input  logic            pause,
    output logic            idle,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] scnt, scnt_nxt;
    logic          if_pend;
    logic          sel_d;
    logic          sel_if;

    // pause masks fetch everywhere, including the starvation bookkeeping
    assign if_pend = if_req && !pause;
    assign sel_d   = d_req && !(if_pend && (scnt == SLIM));
    assign sel_if  = if_pend && !sel_d;

    assign rdata = mem_rdata;
    assign idle  = (state == IDLE) && !mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;

        case (state)
            IDLE: begin
                // stale mem_rvalid is deliberately ignored here
                if (sel_d) begin
                    mem_req   = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    mem_be    = d_be;
                    if (mem_gnt) begin
                        d_gnt     = 1'b1;
                        state_nxt = WAIT_D;
                    end
                end else if (sel_if) begin
                    mem_req  = 1'b1;
                    mem_addr = if_addr;
                    mem_be   = '1;
                    if (mem_gnt) begin
                        if_gnt    = 1'b1;
                        state_nxt = WAIT_IF;
                    end
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    d_rvalid  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scnt_nxt = scnt;
        if (d_gnt) begin
            if (if_pend) begin
                if (scnt != SLIM) scnt_nxt = scnt + SW'(1);
            end else begin
                scnt_nxt = '0;
            end
        end else if (if_gnt) begin
            scnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_memport_arbiter.sv
// Directed bench for memport_arbiter with a small fixed-latency memory responder.
module tb_memport_arbiter;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] rdata;
    logic        pause, idle;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int          lat = 3;
    logic        gnt_en;
    logic        force_rv;
    int          cnt = 0;
    logic [31:0] last_addr = '0;

    int n_chk  = 0;
    int n_pass = 0;

    memport_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .pause(pause), .idle(idle),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory: answers lat cycles after the handshake, read data = addr ^ K
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            cnt       <= lat;
            last_addr <= mem_addr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign mem_rvalid = (cnt == 1) || force_rv;
    assign mem_rdata  = last_addr ^ K;
    assign mem_gnt    = gnt_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        string exp_seq;
        int    g;
        int    errs;
        bit    seen;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; pause = 1'b0; gnt_en = 1'b1; force_rv = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_idle", idle, 1);
        chk("rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_be}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();

        // fetch only, latency 3
        lat = 3; if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("f_gnt", if_gnt, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we_be", {mem_we, mem_be, mem_wdata}, {1'b0, 4'hf, 32'h0});
        step(); if_req = 1'b0;
        errs = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            if (if_rvalid !== 1'b0) errs++;
            step();
        end
        chk("f_early_rvalid", errs, 0);
        @(negedge clk);
        chk("f_rvalid", if_rvalid, 1);
        chk("f_rdata", rdata, 32'h100 ^ K);
        chk("f_busy", idle, 0);
        step();
        @(negedge clk);
        chk("f_idle", idle, 1);
        chk("f_rvalid_off", if_rvalid, 0);
        step();

        // contention, STARVE_LIM = 4
        lat = 1; if_req = 1'b1; if_addr = 32'h180; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        exp_seq = "DDDDIDDDDI";
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                chk($sformatf("c_grant%0d_is_data", g), d_gnt, exp_seq[g] == "D");
                g++;
            end
            if (d_rvalid) chk("c_d_rdata", rdata, 32'h200 ^ K);
            step();
        end
        if (g < 10) chk("c_grant_timeout", g, 10);
        if_req = 1'b0; d_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = idle;
            step();
        end
        chk("c_drain_idle", seen, 1);

        // store
        lat = 2; d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h300;
        @(negedge clk);
        chk("s_gnt", d_gnt, 1);
        chk("s_mem_we", mem_we, 1);
        chk("s_mem_be", mem_be, 4'b0011);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_addr", mem_addr, 32'h300);
        step(); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("s_early_rvalid", d_rvalid, 0);
        step();
        @(negedge clk);
        chk("s_rvalid", {d_rvalid, if_rvalid}, 2'b10);
        step();

        // pause blocks fetch
        pause = 1'b1; if_req = 1'b1; if_addr = 32'h500;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_gnt !== 1'b0 || idle !== 1'b1 || mem_req !== 1'b0) errs++;
            step();
        end
        chk("p_blocked", errs, 0);
        pause = 1'b0;
        @(negedge clk);
        chk("p_gnt_after_release", if_gnt, 1);
        step(); if_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (if_rvalid) begin
                seen = 1'b1;
                chk("p_rdata", rdata, 32'h500 ^ K);
            end
            step();
        end
        chk("p_rvalid_seen", seen, 1);

        // reset in WAIT_IF, then stale responses
        lat = 4; if_req = 1'b1; if_addr = 32'h600;
        @(negedge clk);
        chk("r_gnt", if_gnt, 1);
        step(); if_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("r_in_reset", {idle, if_rvalid}, 2'b10);
        step(); rst_n = 1'b1; force_rv = 1'b1;
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || idle !== 1'b1) errs++;
            step();
            force_rv = 1'b0;
        end
        chk("r_stale_ignored", errs, 0);
        lat = 1; if_req = 1'b1; if_addr = 32'h700;
        @(negedge clk);
        chk("r_new_gnt", if_gnt, 1);
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("r_new_rvalid", if_rvalid, 1);
        chk("r_new_rdata", rdata, 32'h700 ^ K);
        step();

        // memory backpressure
        gnt_en = 1'b0; d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h400;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== 32'h400 || d_gnt !== 1'b0) errs++;
            step();
        end
        chk("b_held", errs, 0);
        gnt_en = 1'b1;
        @(negedge clk);
        chk("b_gnt", d_gnt, 1);
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("b_rvalid", d_rvalid, 1);
        chk("b_rdata", rdata, 32'h400 ^ K);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
